// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared constants and helpers for the SHA-256 AXI peripheral:
//               round constants, initial hash value, register word offsets,
//               byte-swap and the SHA-256 logical functions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

  // Round constants K[0..63]
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Initial hash value H0..H7
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Register word offsets (byte address bits [5:2])
  localparam logic [3:0] REG_CTRL = 4'h0;
  localparam logic [3:0] REG_DATA = 4'h1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } core_state_e;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, f, g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, b, c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_core.sv
`default_nettype none
// ============================================================================
// Module      : sha256_core
// Description : SHA-256 compression engine with 16-word message buffer.
//               Collects 16 words, then runs 64 rounds (one per clock) on a
//               sliding message schedule and folds the result into H.
// Ports       : aclk, aresetn (async, active-high)
//               init       - load IV, clear count/done, abort compression
//               word_valid - push 'word' into the buffer (ignored while busy)
//               word       - big-endian message word
//               busy, done - status
//               h          - current hash H0..H7 (h[0] = H0)
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_core
  import sha256_pkg::*;
(
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             init,
  input  logic             word_valid,
  input  logic [31:0]      word,
  output logic             busy,
  output logic             done,
  output logic [7:0][31:0] h
);

  core_state_e      state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic [5:0]       round_q, round_d;
  logic             done_q, done_d;
  logic [7:0][31:0] h_q, h_d;
  logic [7:0][31:0] s_q, s_d;    // working variables a..h = s[0]..s[7]
  logic [15:0][31:0] w_q, w_d;   // w[0] is W_t during round t
  logic [31:0]      t1, t2;
  logic             block_full;

  assign block_full = word_valid && (state_q == ST_IDLE) && (count_q == 4'd15);

  // State register
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; init overrides every transition
  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (block_full) state_d = ST_ROUND;
        ST_ROUND: if (round_q == 6'd63) state_d = ST_FINAL;
        ST_FINAL: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = done_q;
    h    = h_q;
  end

  // Datapath
  always_comb begin
    count_d = count_q;
    round_d = round_q;
    done_d  = done_q;
    h_d     = h_q;
    s_d     = s_q;
    w_d     = w_q;
    t1 = s_q[7] + bsig1(s_q[4]) + ch(s_q[4], s_q[5], s_q[6]) + K[round_q] + w_q[0];
    t2 = bsig0(s_q[0]) + maj(s_q[0], s_q[1], s_q[2]);
    if (init) begin
      for (int i = 0; i < 8; i++) h_d[i] = IV[i];
      count_d = 4'd0;
      round_d = 6'd0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (word_valid) begin
            w_d[count_q] = word;
            count_d      = count_q + 4'd1;
            if (count_q == 4'd15) begin
              s_d     = h_q;
              round_d = 6'd0;
              done_d  = 1'b0;
            end
          end
        end
        ST_ROUND: begin
          // Slide the schedule window; the new tail word is W_{t+16}
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
          s_d[0] = t1 + t2;
          s_d[1] = s_q[0];
          s_d[2] = s_q[1];
          s_d[3] = s_q[2];
          s_d[4] = s_q[3] + t1;
          s_d[5] = s_q[4];
          s_d[6] = s_q[5];
          s_d[7] = s_q[6];
          round_d = round_q + 6'd1;
        end
        ST_FINAL: begin
          for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + s_q[i];
          done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      count_q <= 4'd0;
      round_q <= 6'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
      s_q     <= '0;
      w_q     <= '0;
    end else begin
      count_q <= count_d;
      round_q <= round_d;
      done_q  <= done_d;
      h_q     <= h_d;
      s_q     <= s_d;
      w_q     <= w_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sha256_axi_v1_0_s00_axi.sv
`default_nettype none
// ============================================================================
// Module      : sha256_axi_v1_0_s00_axi
// Description : AXI4-Lite slave front end for the SHA-256 core. Decodes the
//               control/status, message push and digest registers.
// Ports       : aclk, aresetn (async, active-high)
//               S_AXI_AW*/W*/B* - write address/data/response channels
//               S_AXI_AR*/R*    - read address/data channels
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_axi_v1_0_s00_axi
  import sha256_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic        wr_fire, rd_fire;
  logic [3:0]  wr_idx, rd_idx;
  logic        core_init, core_push, core_busy, core_done;
  logic [7:0][31:0] core_h;
  logic        unused_bits;

  assign unused_bits = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx    = S_AXI_AWADDR[5:2];
  assign rd_idx    = S_AXI_ARADDR[5:2];
  assign wr_fire   = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire   = arready_q && S_AXI_ARVALID;
  assign core_init = wr_fire && (wr_idx == REG_CTRL) && S_AXI_WDATA[0];
  // Pushes that arrive mid-compression are dropped, never buffered
  assign core_push = wr_fire && (wr_idx == REG_DATA) && !core_busy;

  sha256_core u_core (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .init       (core_init),
    .word_valid (core_push),
    .word       (bswap(S_AXI_WDATA)),
    .busy       (core_busy),
    .done       (core_done),
    .h          (core_h)
  );

  always_comb begin
    // ~awready_q keeps the ready strobe to a single cycle per transfer
    awready_d = !awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = ((wr_idx == REG_DATA) && core_busy) ? RESP_SLVERR : RESP_OKAY;
    end else if (S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    arready_d = !arready_q && S_AXI_ARVALID && !rvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      if (rd_idx == REG_CTRL)  rdata_d = {30'b0, core_done, core_busy};
      else if (rd_idx[3])      rdata_d = bswap(core_h[rd_idx[2:0]]);
      else                     rdata_d = 32'h0;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

`default_nettype wire

// File: tb/tb_sha256_axi_v1_0_s00_axi.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_axi_v1_0_s00_axi
// Description : Directed self-checking bench for the SHA-256 AXI peripheral
//               using known SHA-256 digests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_axi_v1_0_s00_axi;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int total;
  int bad;

  always #5 aclk = ~aclk;

  sha256_axi_v1_0_s00_axi #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready)
  );

  // Message blocks as pushed (little-endian words), word 0 in the top bits
  localparam logic [511:0] HELLO = {32'h6c6c6568, 32'h6f77206f, 32'h80646c72, 384'h0, 32'h58000000};
  localparam logic [511:0] EMPTY = {32'h00000080, 480'h0};
  localparam logic [511:0] ABC   = {32'h80636261, 448'h0, 32'h18000000};
  localparam logic [511:0] NIST1 = {32'h64636261, 32'h65646362, 32'h66656463, 32'h67666564,
                                    32'h68676665, 32'h69686766, 32'h6a696867, 32'h6b6a6968,
                                    32'h6c6b6a69, 32'h6d6c6b6a, 32'h6e6d6c6b, 32'h6f6e6d6c,
                                    32'h706f6e6d, 32'h71706f6e, 32'h00000080, 32'h00000000};
  localparam logic [511:0] NIST2 = {480'h0, 32'hc0010000};

  // Standard big-endian digests
  localparam logic [255:0] HELLO_D = 256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] NIST_D  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    @(posedge aclk); #1;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(posedge aclk); #1; n++; end
    if (!awready) begin
      total++; bad++;
      $error("FAIL aw_timeout addr=%h observed=0 expected=1", a);
    end
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!bvalid) begin
      total++; bad++;
      $error("FAIL b_timeout addr=%h observed=0 expected=1", a);
      resp = 2'bxx;
    end else begin
      resp = bresp;
    end
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
    int n;
    @(posedge aclk); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(posedge aclk); #1; n++; end
    if (!arready) begin
      total++; bad++;
      $error("FAIL ar_timeout addr=%h observed=0 expected=1", a);
    end
    @(posedge aclk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!rvalid) begin
      total++; bad++;
      $error("FAIL r_timeout addr=%h observed=0 expected=1", a);
      d = 'x;
    end else begin
      d = rdata;
    end
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic push_block(input string tag, input logic [511:0] blk);
    logic [1:0] r;
    for (int i = 0; i < 16; i++) begin
      axi_write(6'h04, blk[511-32*i -: 32], r);
      check(tag, {62'b0, r}, 64'd0);
    end
  endtask

  task automatic check_digest(input string tag, input logic [255:0] dig);
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      axi_read(6'(32 + 4*i), d);
      check(tag, {32'b0, d}, {32'b0, swap32(dig[255-32*i -: 32])});
    end
  endtask

  task automatic do_init();
    logic [1:0] r;
    axi_write(6'h00, 32'h1, r);
    check("init_resp", {62'b0, r}, 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    total = 0; bad = 0;
    aresetn = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = 4'hf;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    repeat (4) @(posedge aclk); #1;
    check("reset_outputs", {26'b0, awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata},
          64'd0);
    aresetn = 1'b0;
    axi_read(6'h00, d); check("reset_status", {32'b0, d}, 64'd0);
    axi_read(6'h20, d); check("reset_h0", {32'b0, d}, 64'h67e6096a);

    // hello world
    do_init();
    push_block("push_hello", HELLO);
    repeat (72) @(posedge aclk); #1;
    check_digest("hello", HELLO_D);
    axi_read(6'h00, d); check("hello_status", {32'b0, d}, 64'h2);
    axi_read(6'h10, d); check("unmapped_read", {32'b0, d}, 64'h0);

    // empty message
    do_init();
    push_block("push_empty", EMPTY);
    repeat (72) @(posedge aclk); #1;
    check_digest("empty", EMPTY_D);

    // abc
    do_init();
    push_block("push_abc", ABC);
    repeat (72) @(posedge aclk); #1;
    check_digest("abc", ABC_D);

    // busy status and dropped push while busy
    do_init();
    push_block("push_hello2", HELLO);
    axi_read(6'h00, d); check("busy_status", {32'b0, d}, 64'h1);
    axi_read(6'h20, d); check("h0_while_busy", {32'b0, d}, 64'h67e6096a);
    axi_write(6'h04, 32'hdeadbeef, r); check("busy_push_slverr", {62'b0, r}, 64'h2);
    repeat (72) @(posedge aclk); #1;
    check_digest("hello_after_drop", HELLO_D);

    // init while busy aborts; a following block starts cleanly
    do_init();
    push_block("push_abort", ABC);
    do_init();
    axi_read(6'h00, d); check("abort_status", {32'b0, d}, 64'h0);
    axi_read(6'h20, d); check("abort_h0", {32'b0, d}, 64'h67e6096a);
    push_block("push_abc2", ABC);
    repeat (72) @(posedge aclk); #1;
    check_digest("abc_after_abort", ABC_D);

    // reset mid-compression
    do_init();
    push_block("push_rst", HELLO);
    repeat (20) @(posedge aclk);
    #2 aresetn = 1'b1;
    #1 check("midrst_outputs",
             {26'b0, awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}, 64'd0);
    @(posedge aclk); #1 aresetn = 1'b0;
    axi_read(6'h20, d); check("midrst_h0", {32'b0, d}, 64'h67e6096a);
    axi_read(6'h00, d); check("midrst_status", {32'b0, d}, 64'h0);

    // two-block message, chained
    do_init();
    push_block("push_nist1", NIST1);
    repeat (72) @(posedge aclk); #1;
    push_block("push_nist2", NIST2);
    repeat (72) @(posedge aclk); #1;
    check_digest("nist2blk", NIST_D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
